// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and helpers for the parallel-to-serial converter.
//   ser_state_t   : two-state FSM encoding (IDLE / SEND)
//   MIN_LEN       : shortest word length that is accepted
//   mod_to_len()  : converts the bit-count input into a word length
//   len_is_legal(): tells whether a decoded length may be accepted
// The helpers use plain integer arguments so that both the RTL and the
// testbench scoreboard can call them regardless of the bus width.
// -----------------------------------------------------------------------------
package serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int unsigned MIN_LEN = 32'd3;

    // A bit count of zero stands for a full word of 'width' bits.
    function automatic int unsigned mod_to_len(input int unsigned mod,
                                               input int unsigned width);
        int unsigned len;
        if (mod == 32'd0) begin
            len = width;
        end else begin
            len = mod;
        end
        return len;
    endfunction

    // Lengths of one or two bits are too short for the downstream framing.
    function automatic logic len_is_legal(input int unsigned len);
        logic ok;
        if (len >= MIN_LEN) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/serializer_if.sv
// -----------------------------------------------------------------------------
// serializer_if
// Groups the request side and the serial side of the serializer.
//   data_i         : parallel word, MSB is sent first
//   data_mod_i     : number of MSBs to send, 0 = whole word
//   data_val_i     : one-cycle request strobe
//   ser_data_o     : serial bit
//   ser_data_val_o : serial bit valid
//   busy_o         : word being shifted out
// Modports: master = word producer, slave = serializer.
// -----------------------------------------------------------------------------
interface serializer_if #(
    parameter int DATA_BUS_WIDTH = 16
);
    import serializer_pkg::*;

    localparam int MOD_WIDTH = $clog2(DATA_BUS_WIDTH);

    logic [DATA_BUS_WIDTH-1:0] data_i;
    logic [MOD_WIDTH-1:0]      data_mod_i;
    logic                      data_val_i;
    logic                      ser_data_o;
    logic                      ser_data_val_o;
    logic                      busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );

endinterface

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
// Parallel-to-serial converter. A request latches a word and a bit count;
// the selected MSBs are then shifted out one per clock with a valid flag.
// Ports:
//   clk_i    : clock, rising edge
//   arst_n_i : asynchronous active-low reset
//   bus      : serializer_if.slave (request inputs, serial outputs, busy)
// Timing: accept at edge N, bit k registered at edge N+1+k, outputs return
// to zero at edge N+len+1. The FSM is back in IDLE after the last-bit edge,
// so the next word can be accepted at edge N+len+1.
// -----------------------------------------------------------------------------
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    serializer_if.slave    bus
);

    localparam int MOD_WIDTH = $clog2(DATA_BUS_WIDTH);
    localparam int CNT_WIDTH = MOD_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ser_state_t                state_r;
    ser_state_t                state_next_s;
    logic [DATA_BUS_WIDTH-1:0] shift_r;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [CNT_WIDTH-1:0]      len_s;
    logic                      len_ok_s;
    logic                      accept_s;
    logic                      last_s;
    logic                      ser_data_next_s;
    logic                      ser_val_next_s;
    logic                      busy_next_s;
    logic                      ser_data_r;
    logic                      ser_val_r;
    logic                      busy_r;

    // Request decode: length, legality, acceptance and last-bit detection.
    always_comb begin
        len_s    = CNT_WIDTH'(mod_to_len(32'(bus.data_mod_i), 32'(DATA_BUS_WIDTH)));
        len_ok_s = len_is_legal(32'(len_s));
        // Acceptance follows the FSM rather than the registered busy flag so
        // that a word can follow on the edge where busy drops.
        if (bus.data_val_i && (state_r == IDLE) && len_ok_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == SEND) && (cnt_r == CNT_ONE)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode; these values are registered before leaving the block.
    always_comb begin
        ser_data_next_s = 1'b0;
        ser_val_next_s  = 1'b0;
        busy_next_s     = 1'b0;
        case (state_r)
            IDLE: begin
                ser_data_next_s = 1'b0;
                ser_val_next_s  = 1'b0;
                busy_next_s     = 1'b0;
            end
            SEND: begin
                ser_data_next_s = shift_r[DATA_BUS_WIDTH-1];
                ser_val_next_s  = 1'b1;
                busy_next_s     = 1'b1;
            end
            default: begin
                ser_data_next_s = 1'b0;
                ser_val_next_s  = 1'b0;
                busy_next_s     = 1'b0;
            end
        endcase
    end

    // Shift register and bit counter.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shift_r <= {DATA_BUS_WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else if (accept_s) begin
            shift_r <= bus.data_i;
            cnt_r   <= len_s;
        end else if (state_r == SEND) begin
            shift_r <= {shift_r[DATA_BUS_WIDTH-2:0], 1'b0};
            // Saturate at zero so the counter can never wrap.
            if (cnt_r != CNT_ZERO) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ser_data_r <= 1'b0;
            ser_val_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ser_data_r <= ser_data_next_s;
            ser_val_r  <= ser_val_next_s;
            busy_r     <= busy_next_s;
        end
    end

    assign bus.ser_data_o     = ser_data_r;
    assign bus.ser_data_val_o = ser_val_r;
    assign bus.busy_o         = busy_r;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
// Directed and short random stimulus for serializer. Each accepted request
// pushes its expected serial bits, tagged with the cycle in which they must
// appear, into a queue; a monitor on the falling edge compares valid, busy
// and data against the head of the queue every cycle.
// -----------------------------------------------------------------------------
module tb_serializer;
    import serializer_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;

    logic  clk;
    logic  arst_n;
    int    cyc = 0;
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    free_edge = 0;
    exp_t  q[$];

    serializer_if #(.DATA_BUS_WIDTH(W)) bus();

    serializer #(.DATA_BUS_WIDTH(W)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after rising edge E, cyc == E.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compares {valid, busy, data} against the scoreboard each cycle.
    always @(negedge clk) begin : monitor
        logic exp_val;
        logic exp_bit;
        exp_val = (q.size() > 0) && (q[0].cyc == cyc);
        exp_bit = exp_val ? q[0].b : 1'b0;
        check("serial{val,busy,data}",
              {29'd0, bus.ser_data_val_o, bus.busy_o, bus.ser_data_o},
              {29'd0, exp_val, exp_val, exp_bit});
        if (exp_val) void'(q.pop_front());
    end

    // Drive one request for one cycle; push the expected bits if it is to be accepted.
    task automatic issue(input logic [W-1:0] d, input logic [3:0] m, input bit acc,
                         input logic [W-1:0] bits, input int len);
        int   n;
        exp_t e;
        bus.data_i     = d;
        bus.data_mod_i = m;
        bus.data_val_i = 1'b1;
        n = cyc + 1;
        if (acc) begin
            for (int k = 0; k < len; k++) begin
                e.b   = bits[W-1-k];
                e.cyc = n + 1 + k;
                q.push_back(e);
            end
        end
        @(negedge clk);
        bus.data_val_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || bus.busy_o) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", q.size(), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [3:0]   rm;
        int           edge_n;
        int           rlen;
        bit           racc;

        bus.data_i     = 16'h0000;
        bus.data_mod_i = 4'd0;
        bus.data_val_i = 1'b0;
        arst_n         = 1'b1;
        #1 arst_n = 1'b0;
        #2;
        check("reset ser_data",  {31'd0, bus.ser_data_o},     32'd0);
        check("reset ser_val",   {31'd0, bus.ser_data_val_o}, 32'd0);
        check("reset busy",      {31'd0, bus.busy_o},         32'd0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Full word: 1010_0101_1100_0011.
        issue(16'hA5C3, 4'd0, 1'b1, 16'hA5C3, 16);
        wait_drain();

        // Partial word: 1,1,1,1,0.
        issue(16'hF000, 4'd5, 1'b1, 16'hF000, 5);
        wait_drain();

        // Illegal lengths dropped, then a three-bit word 0,1,1.
        issue(16'hFFFF, 4'd1, 1'b0, 16'h0000, 0);
        issue(16'hFFFF, 4'd2, 1'b0, 16'h0000, 0);
        repeat (3) @(negedge clk);
        issue(16'h6000, 4'd3, 1'b1, 16'h6000, 3);
        wait_drain();

        // Busy collision: pulses at edges N+3 and N+16 dropped, N+17 accepted.
        issue(16'hFFFF, 4'd0, 1'b1, 16'hFFFF, 16);
        repeat (2) @(negedge clk);
        issue(16'h0000, 4'd0, 1'b0, 16'h0000, 0);
        repeat (12) @(negedge clk);
        issue(16'h0000, 4'd0, 1'b0, 16'h0000, 0);
        issue(16'h0000, 4'd0, 1'b1, 16'h0000, 16);
        wait_drain();

        // Reset mid-word after seven bits, then a clean word.
        issue(16'h1234, 4'd0, 1'b1, 16'h1234, 16);
        repeat (7) @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        check("midreset ser_data", {31'd0, bus.ser_data_o},     32'd0);
        check("midreset ser_val",  {31'd0, bus.ser_data_val_o}, 32'd0);
        check("midreset busy",     {31'd0, bus.busy_o},         32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        issue(16'h8001, 4'd0, 1'b1, 16'h8001, 16);
        wait_drain();

        // Short random run with requests also arriving while busy.
        free_edge = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rd     = W'($urandom);
                rm     = 4'($urandom_range(0, 15));
                edge_n = cyc + 1;
                rlen   = int'(mod_to_len(32'(rm), 32'(W)));
                racc   = len_is_legal(32'(rlen)) && (edge_n >= free_edge);
                if (racc) free_edge = edge_n + rlen + 1;
                issue(rd, rm, racc, rd, rlen);
            end else begin
                @(negedge clk);
            end
        end
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
